sipo_mc: RTL and testbench



---
 rtl/sipo_mc_pkg.sv | 13 +
 rtl/sync_fifo_fwft.sv | 45 ++++
 rtl/sipo_mc.sv | 84 ++++++++
 tb/tb_sipo_mc.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sipo_mc_pkg.sv
// sipo_mc_pkg: shared widths, bit-order enum and lane slicing helper for sipo_mc
package sipo_mc_pkg;
  typedef enum logic {BIT_ORDER_LSB = 1'b0, BIT_ORDER_MSB = 1'b1} bit_order_e;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int lvl_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with level-derived full/empty and flush
module sync_fifo_fwft
  import sipo_mc_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [DW-1:0]             wdata,
  output logic [DW-1:0]             rdata,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = cnt_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata   = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr + AW'(do_push);
      rptr  <= rptr + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/sipo_mc.sv
// sipo_mc: multi-lane serial-to-parallel deserializer feeding a FWFT FIFO with drop-on-full
module sipo_mc
  import sipo_mc_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int OVF_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [LANES-1:0]          sin,
  input  logic                      sin_valid,
  input  logic                      frame_sync,
  input  logic                      cfg_msb_first,
  input  logic                      flush,
  input  logic                      ovf_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WIDTH-1:0]    out_data,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic [OVF_BITS-1:0]       ovf_cnt,
  output logic                      ovf_sticky
);
  localparam int CW = cnt_w(WIDTH);
  logic [LANES*WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0] bit_cnt;
  bit_order_e mode, eff_mode;
  logic strobe, push, pop, drop, empty;
  assign strobe    = en & sin_valid;
  assign eff_mode  = (bit_cnt == '0 || frame_sync) ? bit_order_e'(cfg_msb_first) : mode;
  assign push      = strobe & ~frame_sync & ~flush & (bit_cnt == CW'(WIDTH - 1));
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign drop      = push & full & ~pop;
  // frame_sync starts the new word from a cleared register so no stale bits survive
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] cur;
    assign cur = frame_sync ? '0 : sr[lane_lo(i, WIDTH) +: WIDTH];
    assign sr_nxt[lane_lo(i, WIDTH) +: WIDTH] = (eff_mode == BIT_ORDER_MSB) ?
      {cur[WIDTH-2:0], sin[i]} : {sin[i], cur[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      mode    <= BIT_ORDER_LSB;
    end else if (flush) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (strobe) begin
      sr      <= sr_nxt;
      bit_cnt <= frame_sync ? CW'(1) : bit_cnt + CW'(1);
      mode    <= eff_mode;
    end else if (frame_sync) begin
      sr      <= '0;
      bit_cnt <= '0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      ovf_cnt    <= ovf_clr ? OVF_BITS'(1) : ovf_cnt + OVF_BITS'(~&ovf_cnt);
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end
  sync_fifo_fwft #(.DW(LANES * WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (sr_nxt),
    .rdata (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_sipo_mc.sv
// tb_sipo_mc: directed self-checking bench for sipo_mc (LANES=2, WIDTH=8, DEPTH=4)
module tb_sipo_mc;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, sin_valid = 1'b0, frame_sync = 1'b0;
  logic cfg_msb_first = 1'b0, flush = 1'b0, ovf_clr = 1'b0, out_ready = 1'b0;
  logic [1:0] sin = '0;
  logic out_valid, full, ovf_sticky;
  logic [15:0] out_data, ovf_cnt;
  logic [2:0] level;
  int checks = 0, failures = 0;
  sipo_mc #(.LANES(2), .WIDTH(8), .DEPTH(4), .OVF_BITS(16)) dut (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .sin_valid(sin_valid),
    .frame_sync(frame_sync), .cfg_msb_first(cfg_msb_first), .flush(flush),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .full(full), .ovf_cnt(ovf_cnt),
    .ovf_sticky(ovf_sticky)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic [1:0] b, input logic fs, input logic rdy);
    @(negedge clk);
    sin = b; sin_valid = 1'b1; frame_sync = fs; out_ready = rdy;
    @(negedge clk);
    sin_valid = 1'b0; frame_sync = 1'b0; out_ready = 1'b0;
  endtask
  task automatic send_word(input logic [7:0] s0, input logic [7:0] s1);
    for (int k = 0; k < 8; k++) send_bit({s1[k], s0[k]}, 1'b0, 1'b0);
  endtask
  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) out_ready = 1'b1; else if (which == 1) flush = 1'b1; else ovf_clr = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf_cnt, 0);
    check("rst_sticky", ovf_sticky, 0);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) send_bit({logic'(k < 4), logic'(k == 0 || k == 2)}, 1'b0, 1'b0);
    check("lsb_not_yet", out_valid, 0);
    send_bit({1'b0, 1'b0}, 1'b0, 1'b0);
    check("lsb_valid", out_valid, 1);
    check("lsb_data", out_data, 16'h0F05);
    check("lsb_level", level, 1);
    pulse(0);
    check("pop_level", level, 0);
    cfg_msb_first = 1'b1;
    send_word(8'h05, 8'h0F);
    check("msb_data", out_data, 16'hF0A0);
    pulse(0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) cfg_msb_first = 1'b0;
      send_bit({logic'(k < 4), logic'(k == 0 || k == 2)}, 1'b0, 1'b0);
    end
    check("toggle_same_word", out_data, 16'hF0A0);
    pulse(0);
    send_word(8'h05, 8'h0F);
    check("toggle_next_word", out_data, 16'h0F05);
    pulse(0);
    for (int w = 1; w <= 5; w++) send_word(8'h10 + 8'(w), 8'h20 + 8'(w));
    check("ovf_level", level, 4);
    check("ovf_full", full, 1);
    check("ovf_cnt", ovf_cnt, 1);
    check("ovf_sticky", ovf_sticky, 1);
    for (int w = 1; w <= 4; w++) begin
      check("drain_data", out_data, {8'h20 + 8'(w), 8'h10 + 8'(w)});
      pulse(0);
    end
    check("drain_empty", out_valid, 0);
    for (int w = 1; w <= 4; w++) send_word(8'h10 + 8'(w), 8'h20 + 8'(w));
    for (int k = 0; k < 7; k++) send_bit(2'b01, 1'b0, 1'b0);
    send_bit(2'b10, 1'b0, 1'b1);
    check("pushpop_level", level, 4);
    check("pushpop_ovf", ovf_cnt, 1);
    check("pushpop_head", out_data, 16'h2212);
    pulse(1);
    check("flush_level", level, 0);
    check("flush_valid", out_valid, 0);
    check("flush_keep_ovf", ovf_cnt, 1);
    pulse(2);
    check("clr_ovf", ovf_cnt, 0);
    check("clr_sticky", ovf_sticky, 0);
    for (int k = 0; k < 3; k++) send_bit(2'b11, 1'b0, 1'b0);
    send_bit({1'b1, 1'b0}, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) send_bit({logic'((8'hA5 >> k) & 1), logic'((8'h3C >> k) & 1)}, 1'b0, 1'b0);
    check("fsync_level", level, 1);
    check("fsync_data", out_data, 16'hA53C);
    pulse(0);
    for (int k = 0; k < 5; k++) send_bit(2'b11, 1'b0, 1'b0);
    pulse(1);
    send_word(8'h5A, 8'h96);
    check("flushmid_level", level, 1);
    check("flushmid_data", out_data, 16'h965A);
    pulse(0);
    send_word(8'h01, 8'h02);
    send_word(8'h03, 8'h04);
    for (int k = 0; k < 3; k++) send_bit(2'b11, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_level", level, 0);
    @(negedge clk);
    rst = 1'b0;
    send_word(8'h77, 8'h18);
    check("post_rst_level", level, 1);
    check("post_rst_data", out_data, 16'h1877);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
